// File: rtl/sreg_update_seq_pkg.sv
// Shared definitions for the special-register write sequencer.
//   - register file indices (ZR, SP, LR, PC, CPSR)
//   - FSM state encoding
//   - CPSR flag field width (flags live in the top NZCV_W bits of CPSR)
package sreg_update_seq_pkg;

  localparam logic [2:0] REG_ZR   = 3'd0;
  localparam logic [2:0] REG_SP   = 3'd4;
  localparam logic [2:0] REG_LR   = 3'd5;
  localparam logic [2:0] REG_PC   = 3'd6;
  localparam logic [2:0] REG_CPSR = 3'd7;

  localparam int unsigned NZCV_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLAG_WR = 3'd1,
    S_BL_LR   = 3'd2,
    S_BL_PC   = 3'd3,
    S_SP_RD   = 3'd4,
    S_SP_WR   = 3'd5
  } state_t;

endpackage

// File: rtl/sreg_update_seq_if.sv
// Bundle of request channels and register-file ports around the sequencer.
//   slave  : the sequencer side (takes requests, drives the register file)
//   master : the execute stage / register file side
interface sreg_update_seq_if #(
  parameter int unsigned DATA_W = 32
);
  // flag update channel
  logic              flag_valid;
  logic              flag_ready;
  logic [3:0]        flag_nzcv;
  logic [DATA_W-1:0] cpsr_cur;
  // branch-and-link channel
  logic              bl_valid;
  logic              bl_ready;
  logic [DATA_W-1:0] bl_target;
  logic [DATA_W-1:0] pc_cur;
  // stack adjust channel
  logic              sp_valid;
  logic              sp_ready;
  logic              sp_push;
  // register file ports
  logic [2:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  // memory side and status
  logic              sp_mem_valid;
  logic [DATA_W-1:0] sp_mem_addr;
  logic              sp_wrap;
  logic              busy;

  modport slave (
    input  flag_valid, flag_nzcv, cpsr_cur,
    input  bl_valid, bl_target, pc_cur,
    input  sp_valid, sp_push,
    input  rd_data,
    output flag_ready, bl_ready, sp_ready,
    output rd_addr, wr_en, wr_addr, wr_data,
    output sp_mem_valid, sp_mem_addr, sp_wrap, busy
  );

  modport master (
    output flag_valid, flag_nzcv, cpsr_cur,
    output bl_valid, bl_target, pc_cur,
    output sp_valid, sp_push,
    output rd_data,
    input  flag_ready, bl_ready, sp_ready,
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  sp_mem_valid, sp_mem_addr, sp_wrap, busy
  );

endinterface

// File: rtl/sreg_req_arbiter.sv
// Fixed-priority request arbiter: BL > SP > FLAG, only while idle.
// Purely combinational; at most one grant is high.
//   idle       in  : sequencer can accept a request this cycle
//   *_valid    in  : request lines
//   *_ready    out : grant / accept strobes
module sreg_req_arbiter (
  input  logic idle,
  input  logic bl_valid,
  input  logic sp_valid,
  input  logic flag_valid,
  output logic bl_ready,
  output logic sp_ready,
  output logic flag_ready
);

  always_comb begin
    bl_ready   = idle & bl_valid;
    sp_ready   = idle & ~bl_valid & sp_valid;
    flag_ready = idle & ~bl_valid & ~sp_valid & flag_valid;
  end

endmodule

// File: rtl/sreg_update_seq.sv
// Write-side sequencer for the special register file (ZR, SP, LR, PC, CPSR).
// Serialises flag updates, branch-and-link and stack adjusts onto the single
// write port, using the single read port to fetch SP.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : request channels, register file ports, SP memory address,
//                  wrap pulse and busy status (see sreg_update_seq_if)
module sreg_update_seq
  import sreg_update_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned SP_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  sreg_update_seq_if.slave    bus
);

  localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] SP_INC = DATA_W'(SP_STEP);

  state_t                    state_q, state_d;
  logic [NZCV_W-1:0]         nzcv_q, nzcv_d;
  logic [DATA_W-NZCV_W-1:0]  cpsr_lo_q, cpsr_lo_d;
  logic [DATA_W-1:0]         target_q, target_d;
  logic [DATA_W-1:0]         pc_q, pc_d;
  logic                      push_q, push_d;
  logic [DATA_W-1:0]         sp_old_q, sp_old_d;

  logic                      bl_gnt, sp_gnt, flag_gnt;
  logic                      idle;
  logic [DATA_W:0]           sp_sum;

  // Holding off grants while reset is asserted keeps an accept from being
  // signalled on an edge that will discard it.
  assign idle = (state_q == S_IDLE) && reset_n;

  sreg_req_arbiter u_arb (
    .idle       (idle),
    .bl_valid   (bus.bl_valid),
    .sp_valid   (bus.sp_valid),
    .flag_valid (bus.flag_valid),
    .bl_ready   (bl_gnt),
    .sp_ready   (sp_gnt),
    .flag_ready (flag_gnt)
  );

  assign bus.bl_ready   = bl_gnt;
  assign bus.sp_ready   = sp_gnt;
  assign bus.flag_ready = flag_gnt;
  assign bus.busy       = (state_q != S_IDLE);

  // One extra MSB: carry out on pop, borrow on push.
  always_comb begin
    if (push_q) sp_sum = {1'b0, sp_old_q} - {1'b0, SP_INC};
    else        sp_sum = {1'b0, sp_old_q} + {1'b0, SP_INC};
  end

  always_comb begin
    state_d   = state_q;
    nzcv_d    = nzcv_q;
    cpsr_lo_d = cpsr_lo_q;
    target_d  = target_q;
    pc_d      = pc_q;
    push_d    = push_q;
    sp_old_d  = sp_old_q;

    bus.rd_addr      = '0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.sp_mem_valid = 1'b0;
    bus.sp_mem_addr  = '0;
    bus.sp_wrap      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bl_gnt) begin
          target_d = bus.bl_target;
          pc_d     = bus.pc_cur;
          state_d  = S_BL_LR;
        end else if (sp_gnt) begin
          push_d   = bus.sp_push;
          state_d  = S_SP_RD;
        end else if (flag_gnt) begin
          nzcv_d    = bus.flag_nzcv;
          cpsr_lo_d = bus.cpsr_cur[DATA_W-NZCV_W-1:0];
          state_d   = S_FLAG_WR;
        end
      end
      S_FLAG_WR: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = REG_CPSR;
        bus.wr_data = {nzcv_q, cpsr_lo_q};
        state_d     = S_IDLE;
      end
      S_BL_LR: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = REG_LR;
        bus.wr_data = pc_q + PC_INC;
        state_d     = S_BL_PC;
      end
      S_BL_PC: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = REG_PC;
        bus.wr_data = target_q;
        state_d     = S_IDLE;
      end
      S_SP_RD: begin
        bus.rd_addr = REG_SP;
        sp_old_d    = bus.rd_data;
        state_d     = S_SP_WR;
      end
      S_SP_WR: begin
        bus.wr_en        = 1'b1;
        bus.wr_addr      = REG_SP;
        bus.wr_data      = sp_sum[DATA_W-1:0];
        bus.sp_mem_valid = 1'b1;
        bus.sp_mem_addr  = push_q ? sp_sum[DATA_W-1:0] : sp_old_q;
        bus.sp_wrap      = sp_sum[DATA_W];
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      nzcv_q    <= '0;
      cpsr_lo_q <= '0;
      target_q  <= '0;
      pc_q      <= '0;
      push_q    <= 1'b0;
      sp_old_q  <= '0;
    end else begin
      state_q   <= state_d;
      nzcv_q    <= nzcv_d;
      cpsr_lo_q <= cpsr_lo_d;
      target_q  <= target_d;
      pc_q      <= pc_d;
      push_q    <= push_d;
      sp_old_q  <= sp_old_d;
    end
  end

endmodule
